mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 38 +++
 rtl/mem_port_arbiter_rr_pick3.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants, state type and helpers for the memory-port arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  // Mux select encodings; SEL_NONE makes the mux drive zero.
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  localparam int TIMEOUT_CYCLES_DEFAULT = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // One-hot grant to mux select.
  function automatic logic [1:0] sel_of(input logic [2:0] onehot);
    case (onehot)
      3'b001:  sel_of = SEL_A;
      3'b010:  sel_of = SEL_B;
      3'b100:  sel_of = SEL_C;
      default: sel_of = SEL_NONE;
    endcase
  endfunction

  // One-hot grant to requester index, used to track the last winner.
  function automatic logic [1:0] idx_of(input logic [2:0] onehot);
    case (onehot)
      3'b001:  idx_of = 2'd0;
      3'b010:  idx_of = 2'd1;
      default: idx_of = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick3.sv
// Round-robin picker for three requesters, scanning from last_winner + 1.
// Latency: combinational.
// Backpressure: none; excluded bits are simply not eligible.
// Ports: req[2:0] requests, last_winner[1:0] index of previous winner,
//        exclude[2:0] bits barred this cycle, pick[2:0] one-hot winner,
//        valid high when pick is non-zero.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] last_winner,
  input  logic [2:0] exclude,
  output logic [2:0] pick,
  output logic       valid
);

  logic [2:0] elig;

  always_comb begin
    elig = req & ~exclude;
    pick = 3'b000;
    case (last_winner)
      2'd0: begin                       // order B, C, A
        if      (elig[1]) pick = 3'b010;
        else if (elig[2]) pick = 3'b100;
        else if (elig[0]) pick = 3'b001;
      end
      2'd1: begin                       // order C, A, B
        if      (elig[2]) pick = 3'b100;
        else if (elig[0]) pick = 3'b001;
        else if (elig[1]) pick = 3'b010;
      end
      default: begin                    // last was C (or illegal 3): A, B, C
        if      (elig[0]) pick = 3'b001;
        else if (elig[1]) pick = 3'b010;
        else if (elig[2]) pick = 3'b100;
      end
    endcase
  end

  assign valid = |elig;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer driving the 3:1 memory-port mux select.
// Latency: req -> gnt/sel one cycle; done -> next grant on the same edge.
// Backpressure: grant held until done (or watchdog expiry with ARB_TIMEOUT_EN).
// Ports: clk, rst (sync, active-high), req[2:0] (A=fetch, B=LSU, C=debug),
//        done (completion pulse), gnt[2:0] one-hot, sel[1:0], busy, timeout.
// Optional macro ARB_TIMEOUT_EN builds the watchdog; otherwise timeout = 0.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  if (NUM_REQ != 3) begin : g_bad_num_req
    $error("mem_port_arbiter: NUM_REQ must be 3");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  arb_state_t state;
  logic [2:0] gnt_q;
  logic [1:0] sel_q;
  logic       busy_q;
  logic [1:0] last_winner;

  logic [2:0] excl;
  logic [2:0] pick;
  logic       pick_vld;
  logic       expire;

  // While busy, the owner sits out the arbitration for the next grant.
  assign excl = (state == BUSY) ? gnt_q : 3'b000;

  rr_pick3 u_pick (
    .req         (req),
    .last_winner (last_winner),
    .exclude     (excl),
    .pick        (pick),
    .valid       (pick_vld)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;
  // done in the same cycle takes precedence, so expiry requires !done.
  assign expire  = (state == BUSY) && !done &&
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt_q       <= 3'b000;
      sel_q       <= SEL_NONE;
      busy_q      <= 1'b0;
      last_winner <= 2'd2;
`ifdef ARB_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= expire;
`endif
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state       <= BUSY;
            gnt_q       <= pick;
            sel_q       <= sel_of(pick);
            busy_q      <= 1'b1;
            last_winner <= idx_of(pick);
`ifdef ARB_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
          end
        end
        BUSY: begin
          if (done || expire) begin
            if (pick_vld) begin
              // Back-to-back handoff to another requester.
              gnt_q       <= pick;
              sel_q       <= sel_of(pick);
              last_winner <= idx_of(pick);
`ifdef ARB_TIMEOUT_EN
              wd_cnt      <= '0;
`endif
            end else if ((req & gnt_q) != 3'b000) begin
              // Sole requester is the owner: re-grant without a gap.
`ifdef ARB_TIMEOUT_EN
              wd_cnt      <= '0;
`endif
            end else begin
              state  <= IDLE;
              gnt_q  <= 3'b000;
              sel_q  <= SEL_NONE;
              busy_q <= 1'b0;
            end
          end else begin
`ifdef ARB_TIMEOUT_EN
            wd_cnt <= wd_cnt + WD_W'(1);
`endif
          end
        end
        default: begin
          state  <= IDLE;
          gnt_q  <= 3'b000;
          sel_q  <= SEL_NONE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, idle, round-robin, hold,
// re-grant, mid-transaction reset and watchdog behaviour.
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic       done;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int checks;
  int failures;

  mem_port_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs changed 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 3'b000; done = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b111; done = 1'b1;
    step(); step();
    checks++;
    if ({gnt, sel, busy, timeout} !== {3'b000, 2'b11, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: gnt=%b sel=%b busy=%b timeout=%b expected 000 11 0 0",
               gnt, sel, busy, timeout);
    end
    rst = 1'b0; req = 3'b000; done = 1'b0;
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({gnt, sel, busy} !== {3'b000, 2'b11, 1'b0}) begin
        failures++;
        $display("FAIL idle_hold[%0d]: gnt=%b sel=%b busy=%b expected 000 11 0",
                 i, gnt, sel, busy);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [3];
    logic [1:0] exp_s [3];
    exp_g[0] = 3'b010; exp_s[0] = 2'b01;
    exp_g[1] = 3'b100; exp_s[1] = 2'b10;
    exp_g[2] = 3'b001; exp_s[2] = 2'b00;
    do_reset();
    req = 3'b111;
    step();
    checks++;
    if ({gnt, sel, busy} !== {3'b001, 2'b00, 1'b1}) begin
      failures++;
      $display("FAIL rr_first: gnt=%b sel=%b busy=%b expected 001 00 1", gnt, sel, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();                      // one busy cycle without done
      done = 1'b1;
      step();
      done = 1'b0;
      checks++;
      if ({gnt, sel, busy} !== {exp_g[i], exp_s[i], 1'b1}) begin
        failures++;
        $display("FAIL rr_next[%0d]: gnt=%b sel=%b busy=%b expected %b %b 1",
                 i, gnt, sel, busy, exp_g[i], exp_s[i]);
      end
    end
    req = 3'b000; done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if ({gnt, sel, busy} !== {3'b000, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL rr_release: gnt=%b sel=%b busy=%b expected 000 11 0", gnt, sel, busy);
    end
  endtask

  task automatic test_drop_req();
    req = 3'b010;
    step();
    req = 3'b000;
    checks++;
    if ({gnt, sel, busy} !== {3'b010, 2'b01, 1'b1}) begin
      failures++;
      $display("FAIL drop_grant: gnt=%b sel=%b busy=%b expected 010 01 1", gnt, sel, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({gnt, sel, busy} !== {3'b010, 2'b01, 1'b1}) begin
        failures++;
        $display("FAIL drop_hold[%0d]: gnt=%b sel=%b busy=%b expected 010 01 1",
                 i, gnt, sel, busy);
      end
    end
    done = 1'b1;
    step();
    checks++;
    if ({gnt, sel, busy} !== {3'b000, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL drop_release: gnt=%b sel=%b busy=%b expected 000 11 0", gnt, sel, busy);
    end
    step();                        // done while idle must be ignored
    done = 1'b0;
    checks++;
    if ({gnt, sel, busy} !== {3'b000, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL done_in_idle: gnt=%b sel=%b busy=%b expected 000 11 0", gnt, sel, busy);
    end
  endtask

  task automatic test_regrant();
    req = 3'b001;
    step(); step();
    done = 1'b1; req = 3'b011;
    step();
    done = 1'b0;
    checks++;
    if ({gnt, sel, busy} !== {3'b010, 2'b01, 1'b1}) begin
      failures++;
      $display("FAIL owner_excluded: gnt=%b sel=%b busy=%b expected 010 01 1", gnt, sel, busy);
    end
    req = 3'b000; done = 1'b1;
    step();
    done = 1'b0; req = 3'b001;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if ({gnt, sel, busy} !== {3'b001, 2'b00, 1'b1}) begin
      failures++;
      $display("FAIL regrant_owner: gnt=%b sel=%b busy=%b expected 001 00 1", gnt, sel, busy);
    end
    req = 3'b000; done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if ({gnt, sel, busy} !== {3'b000, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL regrant_release: gnt=%b sel=%b busy=%b expected 000 11 0", gnt, sel, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b100;
    step();
    checks++;
    if ({gnt, sel} !== {3'b100, 2'b10}) begin
      failures++;
      $display("FAIL mid_c_grant: gnt=%b sel=%b expected 100 10", gnt, sel);
    end
    rst = 1'b1; done = 1'b1;
    step();
    checks++;
    if ({gnt, sel, busy} !== {3'b000, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset_drop: gnt=%b sel=%b busy=%b expected 000 11 0", gnt, sel, busy);
    end
    rst = 1'b0; done = 1'b0; req = 3'b111;
    step();
    checks++;
    if ({gnt, sel, busy} !== {3'b001, 2'b00, 1'b1}) begin
      failures++;
      $display("FAIL mid_reset_a_first: gnt=%b sel=%b busy=%b expected 001 00 1",
               gnt, sel, busy);
    end
    req = 3'b000; done = 1'b1;
    step();
    done = 1'b0;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req = 3'b010;
    step();
    req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({gnt, timeout} !== {3'b010, 1'b0}) begin
        failures++;
        $display("FAIL wd_wait[%0d]: gnt=%b timeout=%b expected 010 0", i, gnt, timeout);
      end
    end
    step();
    checks++;
    if ({gnt, sel, busy, timeout} !== {3'b000, 2'b11, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL wd_expire: gnt=%b sel=%b busy=%b timeout=%b expected 000 11 0 1",
               gnt, sel, busy, timeout);
    end
    step();
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL wd_pulse_width: timeout=%b expected 0", timeout);
    end
    req = 3'b010;
    step();
    req = 3'b000;
    step(); step(); step();
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if ({gnt, busy, timeout} !== {3'b000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL wd_done_wins: gnt=%b busy=%b timeout=%b expected 000 0 0",
               gnt, busy, timeout);
    end
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    req = 3'b010;
    step();
    req = 3'b000;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({gnt, busy, timeout} !== {3'b010, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL hold_forever[%0d]: gnt=%b busy=%b timeout=%b expected 010 1 0",
                 i, gnt, busy, timeout);
      end
    end
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if ({gnt, sel, busy} !== {3'b000, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL hold_release: gnt=%b sel=%b busy=%b expected 000 11 0", gnt, sel, busy);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; req = 3'b000; done = 1'b0;
    test_reset();
    test_idle_hold();
    test_round_robin();
    test_drop_req();
    test_regrant();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
